// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: opcode values, load-FSM encoding,
// and bit positions inside the flag and button vectors.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GOT_A = 2'd1,
        ST_GOT_B = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // o_flags = {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int BTN_A  = 2;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (A, B, OP) -> result, carry/borrow, signed overflow
// and an illegal-opcode indication. Shifts act on A by B's low log2(NB_DATA) bits.
module alu_core #(
    parameter int NB_DATA = 6,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] a_i,
    input  logic [NB_DATA-1:0] b_i,
    input  logic [NB_OP-1:0]   op_i,
    output logic [NB_DATA-1:0] result_o,
    output logic               carry_o,
    output logic               overflow_o,
    output logic               illegal_o
);
    import alu_pkg::*;

    localparam int NB_SH = $clog2(NB_DATA);
    localparam int MSB   = NB_DATA - 1;

    logic [NB_SH-1:0] shamt;
    logic [NB_DATA:0] sum_ext;
    logic [NB_DATA:0] diff_ext;

    assign shamt    = b_i[NB_SH-1:0];
    assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
    // The extra MSB of the difference is the borrow out of an unsigned subtract.
    assign diff_ext = {1'b0, a_i} - {1'b0, b_i};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        illegal_o  = 1'b0;
        case (op_i)
            NB_OP'(OP_ADD): begin
                result_o   = sum_ext[NB_DATA-1:0];
                carry_o    = sum_ext[NB_DATA];
                overflow_o = (a_i[MSB] == b_i[MSB]) && (sum_ext[MSB] != a_i[MSB]);
            end
            NB_OP'(OP_SUB): begin
                result_o   = diff_ext[NB_DATA-1:0];
                carry_o    = diff_ext[NB_DATA];
                overflow_o = (a_i[MSB] != b_i[MSB]) && (diff_ext[MSB] != a_i[MSB]);
            end
            NB_OP'(OP_AND): result_o = a_i & b_i;
            NB_OP'(OP_OR):  result_o = a_i | b_i;
            NB_OP'(OP_XOR): result_o = a_i ^ b_i;
            NB_OP'(OP_NOR): result_o = ~(a_i | b_i);
            NB_OP'(OP_SRA): result_o = $signed(a_i) >>> shamt;
            NB_OP'(OP_SRL): result_o = a_i >> shamt;
            default:        illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_top.sv
// Board-facing ALU sequencer: synchronizes and debounces three load buttons,
// loads A/B/OP from shared switches under an order-checking FSM, registers the result.
module alu_seq_top
    import alu_pkg::*;
#(
    parameter int NB_DATA         = 6,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STRICT_ORDER    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic [2:0]         i_buttons,
    output logic [NB_DATA-1:0] o_led,
    output logic [3:0]         o_flags,
    output logic               o_valid,
    output logic               o_err,
    output logic [1:0]         o_state
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam bit STRICT = (STRICT_ORDER != 0);

    // Two-flop synchronizer: the buttons are asynchronous to clock.
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking so sync2_q takes the previous sync1_q, forming a real two-stage chain.
            sync1_q <= i_buttons;
            sync2_q <= sync1_q;
        end
    end

    logic [2:0] pulse;

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic             lvl_q, lvl_d, prev_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            lvl_d = lvl_q;
            cnt_d = '0;
            if (DEBOUNCE_CYCLES == 0) begin
                lvl_d = sync2_q[g];
            end else if (sync2_q[g] != lvl_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) lvl_d = sync2_q[g];
                else                                      cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                lvl_q  <= 1'b0;
                prev_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                lvl_q  <= lvl_d;
                prev_q <= lvl_q;
                cnt_q  <= cnt_d;
            end
        end

        assign pulse[g] = lvl_q & ~prev_q;
    end

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               exec_q, exec_d;
    logic [NB_DATA-1:0] led_q, led_d;
    logic [3:0]         flags_q, flags_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [NB_DATA-1:0] alu_result;
    logic               alu_carry, alu_ovf, alu_illegal;
    logic               multi_press;

    alu_core #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu_core (
        .a_i        (a_q),
        .b_i        (b_q),
        .op_i       (op_q),
        .result_o   (alu_result),
        .carry_o    (alu_carry),
        .overflow_o (alu_ovf),
        .illegal_o  (alu_illegal)
    );

    assign multi_press = (pulse[0] & pulse[1]) | (pulse[0] & pulse[2]) | (pulse[1] & pulse[2]);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        exec_d  = 1'b0;
        led_d   = led_q;
        flags_d = flags_q;
        valid_d = valid_q;
        err_d   = err_q;

        // Result update happens the edge after OP is loaded; a coincident A/B load below wins on o_valid.
        if (exec_q) begin
            valid_d = 1'b1;
            flags_d = '0;
            if (alu_illegal) begin
                led_d           = '0;
                flags_d[FLAG_Z] = 1'b1;
                err_d           = 1'b1;
            end else begin
                led_d           = alu_result;
                flags_d[FLAG_N] = alu_result[NB_DATA-1];
                flags_d[FLAG_Z] = (alu_result == '0);
                flags_d[FLAG_C] = alu_carry;
                flags_d[FLAG_V] = alu_ovf;
            end
        end

        if (multi_press) begin
            err_d = 1'b1;
        end else if (pulse[BTN_A]) begin
            a_d     = i_sw;
            state_d = ST_GOT_A;
            valid_d = 1'b0;
        end else if (pulse[BTN_B]) begin
            if (STRICT && (state_q == ST_IDLE || state_q == ST_DONE)) begin
                err_d = 1'b1;
            end else begin
                b_d     = i_sw;
                state_d = ST_GOT_B;
                valid_d = 1'b0;
            end
        end else if (pulse[BTN_OP]) begin
            if (STRICT && state_q != ST_GOT_B) begin
                err_d = 1'b1;
            end else begin
                op_d    = i_sw[NB_OP-1:0];
                state_d = ST_DONE;
                exec_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            exec_q  <= 1'b0;
            led_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            exec_q  <= exec_d;
            led_q   <= led_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_led   = led_q;
    assign o_flags = flags_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_state = state_q;

endmodule
